// File: rtl/dht_pkg.sv
// Shared types and helpers for the DHT single-wire sensor reader.
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } dht_state_t;

  localparam int CSUM_W = 8;

  function automatic int unsigned cycles_per_us(input int unsigned clk_hz);
    return clk_hz / 32'd1000000;
  endfunction

endpackage

// File: rtl/dht_sensor_reader_if.sv
// Host-side request/result bundle for dht_sensor_reader.
interface dht_sensor_reader_if #(
  parameter int unsigned NUM_BITS = 40
);
  logic                start;
  logic [NUM_BITS-1:0] data_out;
  logic                valid;
  logic                busy;
  logic                err_timeout;
  logic                err_csum;

  modport master (
    output start,
    input  data_out, valid, busy, err_timeout, err_csum
  );

  modport slave (
    input  start,
    output data_out, valid, busy, err_timeout, err_csum
  );
endinterface

// File: rtl/us_tick_gen.sv
// Free-running 1 us strobe derived from the system clock.
module us_tick_gen
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ = 125000000
) (
  input  logic clk_125M,
  input  logic nRST,
  output logic tick_us
);

  localparam int unsigned DIV = cycles_per_us(CLK_HZ);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk_125M) begin
    if (!nRST) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == '0);
      if (r_cnt == '0) r_cnt <= LOAD;
      else             r_cnt <= r_cnt - CW'(1);
    end
  end

  assign tick_us = r_tick;

endmodule

// File: rtl/dht_sensor_reader.sv
// DHT-style single-wire sensor reader. Define DHT_AUTO_POLL_EN to self-trigger
// a read POLL_MS after every return to IDLE.
//
// state      | meaning
// IDLE       | waiting for start (or poll)
// START_LOW  | host holds line low
// RELEASE    | line released, waiting for sensor to pull low
// RESP_LOW   | sensor response low phase
// RESP_HIGH  | sensor response high phase
// BIT_LOW    | low lead-in of a data bit
// BIT_HIGH   | high phase being measured
// CHECK      | checksum compare, result pulse
module dht_sensor_reader
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 125000000,
  parameter int unsigned NUM_BITS      = 40,
  parameter int unsigned START_LOW_US  = 19000,
  parameter int unsigned TIMEOUT_US    = 100,
  parameter int unsigned BIT_THRESH_US = 50,
  parameter int unsigned POLL_MS       = 500
) (
  input  logic                clk_125M,
  input  logic                nRST,
  input  logic                start,
  inout  wire                 Data,
  output logic [NUM_BITS-1:0] data_out,
  output logic                valid,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_csum
);

  localparam int unsigned T_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int TW = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_START = TW'(START_LOW_US - 1);
  localparam logic [TW-1:0] T_PHASE = TW'(TIMEOUT_US);
  // Timer counts down from T_PHASE, so "elapsed > threshold" is "remaining < T_ONE".
  localparam logic [TW-1:0] T_ONE   = TW'(TIMEOUT_US - BIT_THRESH_US);
  localparam int BW = $clog2(NUM_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
  localparam int NBYTES = NUM_BITS / CSUM_W;
  localparam bit CFG_OK = (NUM_BITS % CSUM_W == 0) && (NUM_BITS >= 16) && (POLL_MS > 0);

  dht_state_t          r_state;
  logic                r_oe;
  logic [1:0]          r_sync;
  logic [TW-1:0]       r_tmr;
  logic [BW-1:0]       r_bit_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_data;
  logic                r_seen_high;
  logic                r_valid;
  logic                r_err_to;
  logic                r_err_cs;

  logic                w_tick;
  logic                w_line;
  logic                w_phase_done;
  logic                w_poll_fire;
  logic                w_csum_ok;
  logic [CSUM_W-1:0]   w_sum;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_125M (clk_125M),
    .nRST     (nRST),
    .tick_us  (w_tick)
  );

  assign Data   = r_oe ? 1'b0 : 1'bz;
  assign w_line = r_sync[1];

  always_comb begin
    w_sum = '0;
    for (int i = 1; i < NBYTES; i++) w_sum = w_sum + r_shift[i*CSUM_W +: CSUM_W];
    w_csum_ok = (w_sum == r_shift[CSUM_W-1:0]);
  end

  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      ST_RELEASE:   w_phase_done = r_seen_high && !w_line;
      ST_RESP_LOW:  w_phase_done = w_line;
      ST_RESP_HIGH: w_phase_done = !w_line;
      ST_BIT_LOW:   w_phase_done = w_line;
      ST_BIT_HIGH:  w_phase_done = !w_line;
      default:      w_phase_done = 1'b0;
    endcase
  end

`ifdef DHT_AUTO_POLL_EN
  localparam int unsigned POLL_US = POLL_MS * 1000;
  localparam int PW = $clog2(POLL_US + 1);

  logic [PW-1:0] r_poll_cnt;

  assign w_poll_fire = (r_state == ST_IDLE) && w_tick && (r_poll_cnt == PW'(POLL_US - 1));

  always_ff @(posedge clk_125M) begin
    if (!nRST)                                   r_poll_cnt <= '0;
    else if ((r_state != ST_IDLE) || w_poll_fire) r_poll_cnt <= '0;
    else if (w_tick)                             r_poll_cnt <= r_poll_cnt + PW'(1);
  end
`else
  assign w_poll_fire = 1'b0;
`endif

  always_ff @(posedge clk_125M) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_oe        <= 1'b0;
      r_sync      <= 2'b11;
      r_tmr       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_seen_high <= 1'b0;
      r_valid     <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_cs    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], Data};
      r_valid  <= 1'b0;
      r_err_to <= 1'b0;
      r_err_cs <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (CFG_OK && (start || w_poll_fire)) begin
            r_state <= ST_START_LOW;
            r_oe    <= 1'b1;
            r_tmr   <= T_START;
          end
        end

        ST_START_LOW: begin
          if (w_tick) begin
            if (r_tmr == '0) begin
              r_state     <= ST_RELEASE;
              r_oe        <= 1'b0;
              r_tmr       <= T_PHASE;
              r_seen_high <= 1'b0;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
        end

        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (w_csum_ok) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end else begin
            r_err_cs <= 1'b1;
          end
        end

        default: begin
          // The synchronised line still shows the start pulse for a few cycles
          // after release, so RELEASE only accepts a low once it has seen high.
          if (r_state == ST_RELEASE && w_line) r_seen_high <= 1'b1;

          if (w_phase_done) begin
            r_tmr <= T_PHASE;
            case (r_state)
              ST_RELEASE:   r_state <= ST_RESP_LOW;
              ST_RESP_LOW:  r_state <= ST_RESP_HIGH;
              ST_RESP_HIGH: begin
                r_state   <= ST_BIT_LOW;
                r_bit_cnt <= BIT_LAST;
              end
              ST_BIT_LOW:   r_state <= ST_BIT_HIGH;
              ST_BIT_HIGH: begin
                r_shift <= {r_shift[NUM_BITS-2:0], (r_tmr < T_ONE)};
                if (r_bit_cnt == '0) begin
                  r_state <= ST_CHECK;
                end else begin
                  r_bit_cnt <= r_bit_cnt - BW'(1);
                  r_state   <= ST_BIT_LOW;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end else if (w_tick) begin
            if (r_tmr == '0) begin
              r_state  <= ST_IDLE;
              r_err_to <= 1'b1;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign valid       = r_valid;
  assign busy        = (r_state != ST_IDLE);
  assign err_timeout = r_err_to;
  assign err_csum    = r_err_cs;

endmodule

// File: tb/tb_dht_sensor_reader.sv
// Scoreboard bench for dht_sensor_reader with a behavioural sensor on the line.
`timescale 1ns/1ps
module tb_dht_sensor_reader;

  localparam int unsigned CLK_HZ = 2000000;
  localparam int NB = 40;
  localparam logic [2:0] EV_VALID = 3'b100;
  localparam logic [2:0] EV_CSUM  = 3'b010;
  localparam logic [2:0] EV_TO    = 3'b001;

  localparam logic [NB-1:0] FA = 40'h350018004D;
  localparam logic [NB-1:0] FB = 40'h350018004E;
  localparam logic [NB-1:0] FC = 40'h123456009C;

  typedef struct {
    logic [2:0]    code;
    logic [NB-1:0] data;
  } exp_t;

  logic clk_125M = 1'b0;
  logic nRST = 1'b0;
  logic r_sns_low = 1'b0;
  wire  Data;

  pullup (Data);
  assign Data = r_sns_low ? 1'b0 : 1'bz;

  dht_sensor_reader_if #(.NUM_BITS(NB)) u_if ();

  dht_sensor_reader #(
    .CLK_HZ        (CLK_HZ),
    .NUM_BITS      (NB),
    .START_LOW_US  (50),
    .TIMEOUT_US    (100),
    .BIT_THRESH_US (50),
    .POLL_MS       (1)
  ) dut (
    .clk_125M    (clk_125M),
    .nRST        (nRST),
    .start       (u_if.start),
    .Data        (Data),
    .data_out    (u_if.data_out),
    .valid       (u_if.valid),
    .busy        (u_if.busy),
    .err_timeout (u_if.err_timeout),
    .err_csum    (u_if.err_csum)
  );

  always #250 clk_125M = ~clk_125M;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t q[$];
  exp_t m_e;
  logic [2:0] m_code;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every result pulse is matched against the oldest pending expectation.
  always @(negedge clk_125M) begin
    if (nRST && (u_if.valid || u_if.err_csum || u_if.err_timeout)) begin
      m_code = {u_if.valid, u_if.err_csum, u_if.err_timeout};
      if (q.size() == 0) begin
        chk("unexpected_event", {61'd0, m_code}, 64'd0);
      end else begin
        m_e = q.pop_front();
        chk("event_kind", {61'd0, m_code}, {61'd0, m_e.code});
        chk("data_out_after_event", {24'd0, u_if.data_out}, {24'd0, m_e.data});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk_125M);
    u_if.start = 1'b1;
    @(negedge clk_125M);
    u_if.start = 1'b0;
  endtask

  task automatic wait_line(input logic lvl, input int max_us, output bit ok);
    for (int i = 0; i < max_us * 10; i++) begin
      if (Data === lvl) break;
      #100;
    end
    ok = (Data === lvl);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_125M);
      if (!u_if.busy) break;
    end
    chk("busy_fall", {63'd0, u_if.busy}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_released"}, {63'd0, (Data === 1'b1)}, 64'd1);
    chk({tag, "_data_out"}, {24'd0, u_if.data_out}, 64'd0);
    chk({tag, "_valid"}, {63'd0, u_if.valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, u_if.busy}, 64'd0);
    chk({tag, "_err_timeout"}, {63'd0, u_if.err_timeout}, 64'd0);
    chk({tag, "_err_csum"}, {63'd0, u_if.err_csum}, 64'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk_125M);
    nRST = 1'b0;
    @(posedge clk_125M);
    #1;
    check_reset_outputs("rst_mid");
    repeat (4) @(negedge clk_125M);
    nRST = 1'b1;
  endtask

  // start_bit / rst_bit select the bit during which a stray start or a reset occurs.
  task automatic sensor_frame(input logic [NB-1:0] f, input int start_bit, input int rst_bit);
    bit ok;
    wait_line(1'b0, 200, ok);
    chk("host_start_low", {63'd0, ok}, 64'd1);
    wait_line(1'b1, 200, ok);
    chk("host_release", {63'd0, ok}, 64'd1);
    #20000;
    r_sns_low = 1'b1;
    #80000;
    r_sns_low = 1'b0;
    #80000;
    for (int b = 0; b < NB; b++) begin
      r_sns_low = 1'b1;
      if (b == start_bit) begin
        pulse_start();
        chk("busy_at_ignored_start", {63'd0, u_if.busy}, 64'd1);
      end
      #30000;
      r_sns_low = 1'b0;
      if (b == rst_bit) begin
        #10000;
        reset_mid();
        return;
      end
      if (f[NB-1-b]) #70000;
      else           #25000;
    end
    r_sns_low = 1'b1;
    #30000;
    r_sns_low = 1'b0;
  endtask

  initial begin
    #30ms;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", q.size());
    $fatal(1, "watchdog");
  end

`ifdef DHT_AUTO_POLL_EN
  initial begin
    bit     ok;
    longint t0;
    longint dt;
    u_if.start = 1'b0;
    repeat (5) @(negedge clk_125M);
    check_reset_outputs("reset");
    q.push_back('{EV_TO, '0});
    q.push_back('{EV_TO, '0});
    nRST = 1'b1;
    t0 = $time;
    wait_line(1'b0, 1500, ok);
    chk("poll1_start_low", {63'd0, ok}, 64'd1);
    dt = ($time - t0) / 1000;
    chk("poll1_delay_window", {63'd0, (dt >= 998 && dt <= 1003)}, 64'd1);
    wait_idle();
    t0 = $time;
    wait_line(1'b0, 1500, ok);
    chk("poll2_start_low", {63'd0, ok}, 64'd1);
    dt = ($time - t0) / 1000;
    chk("poll2_delay_window", {63'd0, (dt >= 998 && dt <= 1003)}, 64'd1);
    wait_idle();
    #10000;
    chk("scoreboard_drained", q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
`else
  initial begin
    bit     ok;
    bit     found;
    longint t0;
    longint dt;
    u_if.start = 1'b0;
    repeat (5) @(negedge clk_125M);
    check_reset_outputs("reset");
    nRST = 1'b1;
    #20000;

    q.push_back('{EV_VALID, FA});
    pulse_start();
    sensor_frame(FA, -1, -1);
    wait_idle();
    #50000;

    q.push_back('{EV_CSUM, FA});
    pulse_start();
    sensor_frame(FB, -1, -1);
    wait_idle();
    #50000;

    q.push_back('{EV_TO, FA});
    pulse_start();
    wait_line(1'b0, 200, ok);
    chk("to_host_start_low", {63'd0, ok}, 64'd1);
    wait_line(1'b1, 200, ok);
    chk("to_host_release", {63'd0, ok}, 64'd1);
    t0 = $time;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_125M);
      if (u_if.err_timeout) begin
        found = 1'b1;
        break;
      end
    end
    dt = ($time - t0) / 1000;
    chk("timeout_seen", {63'd0, found}, 64'd1);
    chk("timeout_delay_window", {63'd0, (dt >= 99 && dt <= 103)}, 64'd1);
    @(negedge clk_125M);
    chk("timeout_busy", {63'd0, u_if.busy}, 64'd0);
    chk("timeout_data_released", {63'd0, (Data === 1'b1)}, 64'd1);
    #50000;

    q.push_back('{EV_VALID, FC});
    pulse_start();
    sensor_frame(FC, 10, -1);
    wait_idle();
    #50000;

    pulse_start();
    sensor_frame(FA, -1, 20);
    #200000;
    q.push_back('{EV_VALID, FC});
    pulse_start();
    sensor_frame(FC, -1, -1);
    wait_idle();
    #50000;

    pulse_start();
    wait_line(1'b0, 200, ok);
    chk("rst_start_low_seen", {63'd0, ok}, 64'd1);
    #5000;
    @(negedge clk_125M);
    nRST = 1'b0;
    @(posedge clk_125M);
    #1;
    check_reset_outputs("rst_in_start_low");
    repeat (3) @(negedge clk_125M);
    nRST = 1'b1;

    #20000;
    chk("scoreboard_drained", q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
`endif

endmodule
